mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, 1-cycle-read-latency word memory between the CPU's instruction-fetch port and data-access port. This lets the five-stage core run from a unified instruction/data BRAM. Each cycle the block grants at most one requester, drives the memory port, and routes the returned read data back to its owner with a valid pulse. Data accesses have priority over fetches; a starvation counter bounds how long a fetch can be held off.

## Interface
- ADDR_W, 10, word-address width of the shared memory
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- STARVE_MAX, 4, consecutive denied fetch cycles after which the fetch port wins; range 1..15

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata is new this cycle
- if_rdata  out  DATA_W  last fetched word, held between pulses
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables for writes
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse on read return; writes never pulse
- d_rdata  out  DATA_W  last read data word, held between pulses
- mem_en  out  1  memory port enable
- mem_we  out  DATA_W/8  per-byte write strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after an enabled read

## Operation
- The grant decision is combinational within the cycle. The memory port is driven combinationally from the winner.
- At most one of if_gnt and d_gnt is high in any cycle.
- Priority:
  - Both requesting and starve_cnt < STARVE_MAX: the data port wins.
  - Both requesting and starve_cnt == STARVE_MAX: the fetch port wins.
  - Only one requesting: that one wins.
- Data write grant: mem_en=1, mem_we=d_be, mem_addr=d_addr, mem_wdata=d_wdata.
- Any read grant: mem_en=1, mem_we=0.
- No grant: mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care, driven 0.
- starve_cnt is 4 bits:
  - Increments, saturating at STARVE_MAX, when if_req=1 and d_gnt=1.
  - Clears when if_gnt=1 or if_req=0.
- Return FSM (the state records the operation issued in the previous cycle):
  - IDLE → IF_RD on if_gnt; → D_RD on d_gnt with d_we=0; → D_WR on d_gnt with d_we=1; otherwise stays IDLE.
  - IF_RD, D_RD and D_WR take the same next-state rules as IDLE. Back-to-back grants are allowed, so there are no bubbles.
  - In IF_RD: if_rvalid=1 and if_rdata captures mem_rdata.
  - In D_RD: d_rvalid=1 and d_rdata captures mem_rdata.
  - D_WR produces no return.
- if_rvalid and d_rvalid are registered-state decodes and are never high together.

## Timing
- Grant latency is 0 cycles from req when the request wins.
- Read data latency is 1 cycle: the rvalid pulse comes in the cycle after the grant. The captured rdata is visible in the cycle after that pulse, from the holding register; it is also passed through combinationally during the pulse cycle.
- A write completes in the grant cycle.
- Reset values: state=IDLE, starve_cnt=0, if_rdata=0, d_rdata=0.
- While rst=1: if_gnt, d_gnt, mem_en, mem_we, if_rvalid and d_rvalid are all forced to 0.
- Reset mid-read: the pending return is discarded and no rvalid is produced in the cycle after rst deasserts.
- A requester that drops req before its grant is simply ignored; this is legal but discouraged.
- Maximum fetch wait under continuous data traffic is STARVE_MAX cycles; the fetch is granted in cycle STARVE_MAX+1.

## Structure
- Shared package mem_arb_pkg holds:
  - the return-state enum (ARB_IDLE, ARB_IF_RD, ARB_D_RD, ARB_D_WR);
  - default ADDR_W/DATA_W constants shared with the BRAM wrapper;
  - the STARVE_CNT_W=4 constant.
- One natural sub-module: mem_arb_starve_cnt, the saturating counter with clear, taking inputs inc, clr and max and outputting at_max.

## Test plan
- Fetch only: if_req=1, if_addr=0x004 with mem[4]=0x00500093. Expect if_gnt=1 and mem_en=1 that cycle, then if_rvalid=1 and if_rdata=0x00500093 the next cycle.
- Contention: if_req=1 and d_req=1 (read, addr 0x010) in the same cycle. Expect d_gnt=1 and if_gnt=0, d_rvalid next cycle, and if_gnt the following cycle once d_req drops.
- Starvation: d_req held high on continuous reads with STARVE_MAX=4 and if_req=1. Expect d_gnt in cycles 1-4, if_gnt in cycle 5, then starve_cnt=0 and the data port wins again.
- Byte write: d_req=1, d_we=1, d_addr=0x020, d_be=4'b0011, d_wdata=0xAABBCCDD. Expect mem_we=4'b0011 and no d_rvalid. A subsequent read of 0x020 returns the low half 0xCCDD merged with the old upper bytes.
- Back-to-back: alternating grants for data read 0x1, fetch 0x2, data read 0x3. Expect rvalid pulses on d, then if, then d in consecutive cycles with the matching data.
- Reset mid-read: grant a data read, then assert rst the next cycle. Expect d_rvalid=0, all grants 0 and d_rdata=0; after release the first grant behaves normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified I/D memory port
//               arbiter and its BRAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Default geometry of the unified instruction/data BRAM
    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;

    // Width of the fetch starvation counter (holds 0..15)
    localparam int STARVE_CNT_W   = 4;

    // Operation issued to the memory in the previous cycle
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF_RD = 2'd1,
        ARB_D_RD  = 2'd2,
        ARB_D_WR  = 2'd3
    } arb_state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve_cnt
// Description : Saturating up-counter with synchronous clear. Counts the
//               consecutive cycles a fetch is denied; at_max tells the
//               arbiter to hand the port to the fetch side.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int CNT_W = STARVE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] max,
    output logic             at_max
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; increment stops once the limit is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt < max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_max = (r_cnt >= max);

endmodule : mem_arb_starve_cnt
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, 1-cycle-latency word memory between
//               the instruction-fetch and data-access ports. Data has
//               priority; a starvation counter bounds the fetch wait. Read
//               data is routed back to its owner with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    // Instruction-fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // Data-access port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // Shared memory port
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [STARVE_CNT_W-1:0] c_starve_max = STARVE_CNT_W'(STARVE_MAX);

    arb_state_t         r_state;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_d_rdata;

    logic               w_at_max;
    logic               w_d_win;
    logic               w_if_win;

    // Fetch is forced through only when it has been held off long enough
    assign w_d_win  = d_req && !(if_req && w_at_max);
    assign w_if_win = if_req && !w_d_win;

    assign d_gnt    = w_d_win  && !rst;
    assign if_gnt   = w_if_win && !rst;

    mem_arb_starve_cnt #(
        .CNT_W (STARVE_CNT_W)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (if_req && d_gnt),
        .clr    (if_gnt || !if_req),
        .max    (c_starve_max),
        .at_max (w_at_max)
    );

    // Steer the memory port from whichever side won this cycle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en   = 1'b1;
            mem_addr = d_addr;
            if (d_we) begin
                mem_we    = d_be;
                mem_wdata = d_wdata;
            end
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Return FSM: remember last cycle's operation and capture its read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (r_state == ARB_IF_RD) begin
                r_if_rdata <= mem_rdata;
            end
            if (r_state == ARB_D_RD) begin
                r_d_rdata <= mem_rdata;
            end
            if (if_gnt) begin
                r_state <= ARB_IF_RD;
            end else if (d_gnt) begin
                r_state <= d_we ? ARB_D_WR : ARB_D_RD;
            end else begin
                r_state <= ARB_IDLE;
            end
        end
    end

    // Valid pulses decode the registered state; reset suppresses them
    assign if_rvalid = (r_state == ARB_IF_RD) && !rst;
    assign d_rvalid  = (r_state == ARB_D_RD)  && !rst;

    // Fresh data passes straight through during the pulse, then is held
    assign if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata   = d_rvalid  ? mem_rdata : r_d_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               behavioural 1-cycle-latency byte-writable BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural BRAM: read-first, byte writes, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        if_req = 1'b1; if_addr = 10'h004; d_req = 1'b1; d_addr = 10'h010;
        #1;
        n_checks++; if (if_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_if_gnt: got %b expected 0", if_gnt); end
        n_checks++; if (d_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_d_gnt: got %b expected 0", d_gnt); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        n_checks++; if (mem_we !== 4'b0000) begin n_errors++; $display("FAIL reset_mem_we: got %b expected 0000", mem_we); end
        n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got if=%b d=%b expected 0 0", if_rvalid, d_rvalid); end
        n_checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got if=%h d=%h expected 0 0", if_rdata, d_rdata); end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 10'h004;
        #1;
        n_checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_errors++; $display("FAIL fetch_gnt: got if=%b d=%b expected 1 0", if_gnt, d_gnt); end
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 4'b0 || mem_addr !== 10'h004) begin n_errors++; $display("FAIL fetch_port: got en=%b we=%b addr=%h expected 1 0000 004", mem_en, mem_we, mem_addr); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL fetch_rvalid: got if=%b d=%b expected 1 0", if_rvalid, d_rvalid); end
        n_checks++; if (if_rdata !== 32'h00500093) begin n_errors++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata); end
        tick();
        n_checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h00500093) begin n_errors++; $display("FAIL fetch_hold: got rvalid=%b rdata=%h expected 0 00500093", if_rvalid, if_rdata); end
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 10'h004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        #1;
        n_checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_errors++; $display("FAIL cont_gnt: got d=%b if=%b expected 1 0", d_gnt, if_gnt); end
        n_checks++; if (mem_addr !== 10'h010) begin n_errors++; $display("FAIL cont_addr: got %h expected 010", mem_addr); end
        tick();
        d_req = 1'b0;
        #1;
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin n_errors++; $display("FAIL cont_d_return: got rvalid=%b rdata=%h expected 1 12345678", d_rvalid, d_rdata); end
        n_checks++; if (if_gnt !== 1'b1 || mem_addr !== 10'h004) begin n_errors++; $display("FAIL cont_if_gnt: got gnt=%b addr=%h expected 1 004", if_gnt, mem_addr); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL cont_if_return: got rvalid=%b rdata=%h d_rvalid=%b expected 1 00500093 0", if_rvalid, if_rdata, d_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        // Cycles 1-4 data wins, cycle 5 fetch is forced through, cycle 6 data again
        logic [5:0] exp_d  = 6'b101111;
        logic [5:0] exp_if = 6'b010000;
        if_req = 1'b1; if_addr = 10'h004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++; if (d_gnt !== exp_d[c] || if_gnt !== exp_if[c]) begin n_errors++; $display("FAIL starve_cycle%0d: got d=%b if=%b expected %b %b", c + 1, d_gnt, if_gnt, exp_d[c], exp_if[c]); end
            if (c == 5) begin
                n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093) begin n_errors++; $display("FAIL starve_if_return: got rvalid=%b rdata=%h expected 1 00500093", if_rvalid, if_rdata); end
            end
            tick();
        end
        idle_inputs();
        #1;
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin n_errors++; $display("FAIL starve_d_return: got rvalid=%b rdata=%h expected 1 12345678", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_byte_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_be = 4'b0011; d_wdata = 32'hAABBCCDD;
        #1;
        n_checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0011) begin n_errors++; $display("FAIL wr_port: got gnt=%b en=%b we=%b expected 1 1 0011", d_gnt, mem_en, mem_we); end
        n_checks++; if (mem_wdata !== 32'hAABBCCDD || mem_addr !== 10'h020) begin n_errors++; $display("FAIL wr_data: got wdata=%h addr=%h expected aabbccdd 020", mem_wdata, mem_addr); end
        tick();
        d_we = 1'b0; d_be = 4'b0000; d_wdata = '0;
        #1;
        n_checks++; if (d_rvalid !== 1'b0 || mem_we !== 4'b0000) begin n_errors++; $display("FAIL wr_no_rvalid: got rvalid=%b we=%b expected 0 0000", d_rvalid, mem_we); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122CCDD) begin n_errors++; $display("FAIL wr_readback: got rvalid=%b rdata=%h expected 1 1122ccdd", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h001;
        #1;
        n_checks++; if (d_gnt !== 1'b1) begin n_errors++; $display("FAIL b2b_gnt1: got %b expected 1", d_gnt); end
        tick();
        d_req = 1'b0; if_req = 1'b1; if_addr = 10'h002;
        #1;
        n_checks++; if (if_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'hA1A1A1A1) begin n_errors++; $display("FAIL b2b_step2: got if_gnt=%b d_rvalid=%b d_rdata=%h expected 1 1 a1a1a1a1", if_gnt, d_rvalid, d_rdata); end
        tick();
        if_req = 1'b0; d_req = 1'b1; d_addr = 10'h003;
        #1;
        n_checks++; if (d_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'hB2B2B2B2 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL b2b_step3: got d_gnt=%b if_rvalid=%b if_rdata=%h d_rvalid=%b expected 1 1 b2b2b2b2 0", d_gnt, if_rvalid, if_rdata, d_rvalid); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC3C3C3C3 || if_rvalid !== 1'b0) begin n_errors++; $display("FAIL b2b_step4: got d_rvalid=%b d_rdata=%h if_rvalid=%b expected 1 c3c3c3c3 0", d_rvalid, d_rdata, if_rvalid); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        #1;
        n_checks++; if (d_gnt !== 1'b1) begin n_errors++; $display("FAIL rmr_gnt: got %b expected 1", d_gnt); end
        tick();
        d_req = 1'b0; if_req = 1'b1; if_addr = 10'h004; rst = 1'b1;
        #1;
        n_checks++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_en !== 1'b0) begin n_errors++; $display("FAIL rmr_in_reset: got d_rvalid=%b d_gnt=%b if_gnt=%b en=%b expected 0 0 0 0", d_rvalid, d_gnt, if_gnt, mem_en); end
        tick();
        rst = 1'b0; idle_inputs();
        #1;
        n_checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin n_errors++; $display("FAIL rmr_after: got d_rvalid=%b if_rvalid=%b d_rdata=%h if_rdata=%h expected 0 0 0 0", d_rvalid, if_rvalid, d_rdata, if_rdata); end
        tick();
        d_req = 1'b1; d_addr = 10'h020;
        #1;
        n_checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1) begin n_errors++; $display("FAIL rmr_regrant: got gnt=%b en=%b expected 1 1", d_gnt, mem_en); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122CCDD) begin n_errors++; $display("FAIL rmr_return: got rvalid=%b rdata=%h expected 1 1122ccdd", d_rvalid, d_rdata); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[10'h001] = 32'hA1A1A1A1;
        mem[10'h002] = 32'hB2B2B2B2;
        mem[10'h003] = 32'hC3C3C3C3;
        mem[10'h004] = 32'h00500093;
        mem[10'h010] = 32'h12345678;
        mem[10'h020] = 32'h11223344;

        test_reset();
        test_fetch();
        test_contention();
        test_starvation();
        test_byte_write();
        test_back_to_back();
        test_reset_mid_read();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
